// File: rtl/regfile_sequencer.sv
// Byte-stream instruction sequencer for a 16x8 register file: decodes 1/2-byte
// instructions, runs simple ALU ops, keeps Z/C flags and streams OUT values.
module regfile_sequencer #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned DW    = 8,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] rf_raddr_a,
  output logic [AW-1:0] rf_raddr_b,
  input  logic [DW-1:0] rf_rdata_a,
  input  logic [DW-1:0] rf_rdata_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          flag_z,
  output logic          flag_c,
  output logic          err,
  output logic [DW-1:0] retired
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_OUT  = 4'h7;

  typedef enum logic [1:0] {FETCH, OPND, EXEC, OUTW} state_t;

  state_t          state, state_nxt;
  logic [3:0]      opcode;
  logic [AW-1:0]   rd;
  logic [DW-1:0]   opnd;
  logic [AW-1:0]   rs, rt;
  logic [DW-1:0]   alu_res;
  logic            alu_c;
  logic            is_write, is_alu;
  logic [3:0]      in_op;

  assign rs       = opnd[AW-1:0];
  assign rt       = opnd[2*AW-1:AW];
  assign in_op    = in_data[3:0];
  assign is_write = (opcode >= OP_MOVI) && (opcode <= OP_XOR);
  assign is_alu   = (opcode >= OP_ADD) && (opcode <= OP_XOR);

  // Result is formed from pre-write read data, so rd==rs==rt needs no special case.
  always_comb begin
    alu_res = opnd;
    alu_c   = 1'b0;
    case (opcode)
      OP_MOVI: alu_res = opnd;
      OP_MOV:  alu_res = rf_rdata_a;
      OP_ADD:  {alu_c, alu_res} = (DW+1)'(rf_rdata_a) + (DW+1)'(rf_rdata_b);
      OP_SUB: begin
        alu_res = rf_rdata_a - rf_rdata_b;
        alu_c   = rf_rdata_a < rf_rdata_b;
      end
      OP_AND:  alu_res = rf_rdata_a & rf_rdata_b;
      OP_XOR:  alu_res = rf_rdata_a ^ rf_rdata_b;
      default: alu_res = opnd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = rd;
    rf_wdata   = alu_res;
    rf_raddr_a = (opcode == OP_OUT) ? rd : rs;
    rf_raddr_b = rt;
    case (state)
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_op == OP_OUT)                           state_nxt = EXEC;
          else if ((in_op != OP_NOP) && !in_op[3])       state_nxt = OPND;
        end
      end
      OPND: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        rf_we     = is_write;
        state_nxt = (opcode == OP_OUT) ? OUTW : FETCH;
      end
      OUTW: begin
        if (out_ready) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Instruction fields, flags, output beat and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode    <= OP_NOP;
      rd        <= '0;
      opnd      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      err       <= 1'b0;
      retired   <= '0;
    end else begin
      case (state)
        FETCH: if (in_valid) begin
          opcode <= in_op;
          rd     <= in_data[7:4];
          if (in_op == OP_NOP) retired <= retired + DW'(1);
          if (in_op[3])        err     <= 1'b1;
        end
        OPND: if (in_valid) opnd <= in_data;
        EXEC: begin
          if (is_write) retired <= retired + DW'(1);
          if (is_alu) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
          end
          if (opcode == OP_OUT) begin
            out_data  <= rf_rdata_a;
            out_valid <= 1'b1;
          end
        end
        OUTW: if (out_ready) begin
          out_valid <= 1'b0;
          retired   <= retired + DW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: directed test-plan steps followed by
// randomized instruction streams, checked against an instruction-level model.
module tb_regfile_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] rf_raddr_a, rf_raddr_b;
  logic [7:0] rf_rdata_a, rf_rdata_b;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       flag_z, flag_c, err;
  logic [7:0] retired;

  regfile_sequencer dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flag_z(flag_z), .flag_c(flag_c), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  // External register file: async reads, write lands at posedge.
  logic [7:0] rf_mem [16];
  int         wr_count = 0;
  assign rf_rdata_a = rf_mem[rf_raddr_a];
  assign rf_rdata_b = rf_mem[rf_raddr_b];
  always @(posedge clk) begin
    if (rf_we === 1'b1) begin
      rf_mem[rf_waddr] <= rf_wdata;
      wr_count         <= wr_count + 1;
    end
  end

  // Architectural model state.
  logic [7:0] m_rf [16];
  logic       m_z, m_c, m_err;
  logic [7:0] m_ret;
  int         m_writes;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    bit hs = 1'b0;
    int n  = 0;
    repeat (gap) tick;
    in_data  = b;
    in_valid = 1'b1;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = (in_ready === 1'b1);
      tick;
      n++;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    check("handshake", 32'(hs), 32'd1);
  endtask

  task automatic do_instr(input logic [7:0] b0, input logic [7:0] b1, input int gap, input int hold);
    logic [3:0] op, rd, rs, rt;
    logic [7:0] a, bb, r, expo;
    int         s;
    op = b0[3:0]; rd = b0[7:4]; rs = b1[3:0]; rt = b1[7:4];
    a  = m_rf[rs]; bb = m_rf[rt];
    send(b0, gap);
    if (op >= 4'h8) begin
      m_err = 1'b1;
      @(negedge clk);
      check("illegal_err", 32'(err), 32'(m_err));
      check("illegal_no_retire", 32'(retired), 32'(m_ret));
      check("illegal_no_we", 32'(rf_we), 32'd0);
      check("illegal_in_ready", 32'(in_ready), 32'd1);
      tick;
    end else if (op == 4'h0) begin
      m_ret = m_ret + 8'd1;
      @(negedge clk);
      check("nop_retired", 32'(retired), 32'(m_ret));
      check("nop_no_we", 32'(rf_we), 32'd0);
      check("nop_in_ready", 32'(in_ready), 32'd1);
      tick;
    end else if (op == 4'h7) begin
      expo = m_rf[rd];
      @(negedge clk);
      check("out_exec_in_ready", 32'(in_ready), 32'd0);
      check("out_no_we", 32'(rf_we), 32'd0);
      tick;
      repeat (hold) begin
        @(negedge clk);
        check("outw_valid", 32'(out_valid), 32'd1);
        check("outw_data", 32'(out_data), 32'(expo));
        check("outw_in_ready", 32'(in_ready), 32'd0);
        check("outw_retired", 32'(retired), 32'(m_ret));
        tick;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("out_beat_valid", 32'(out_valid), 32'd1);
      check("out_beat_data", 32'(out_data), 32'(expo));
      tick;
      out_ready = 1'b0;
      m_ret = m_ret + 8'd1;
      @(negedge clk);
      check("out_done_valid", 32'(out_valid), 32'd0);
      check("out_retired", 32'(retired), 32'(m_ret));
      check("out_done_in_ready", 32'(in_ready), 32'd1);
      tick;
    end else begin
      send(b1, $urandom_range(0, 2));
      r = b1;
      case (op)
        4'h2: r = a;
        4'h3: begin s = int'(a) + int'(bb); r = 8'(s % 256); m_c = (s > 255); end
        4'h4: begin s = int'(a) - int'(bb); r = 8'((s + 256) % 256); m_c = (s < 0); end
        4'h5: begin r = a & bb; m_c = 1'b0; end
        4'h6: begin r = a ^ bb; m_c = 1'b0; end
        default: r = b1;
      endcase
      if (op >= 4'h3) m_z = (r == 8'd0);
      @(negedge clk);
      check("exec_we", 32'(rf_we), 32'd1);
      check("exec_waddr", 32'(rf_waddr), 32'(rd));
      check("exec_wdata", 32'(rf_wdata), 32'(r));
      check("exec_in_ready", 32'(in_ready), 32'd0);
      m_rf[rd] = r;
      m_ret    = m_ret + 8'd1;
      m_writes++;
      tick;
      @(negedge clk);
      check("wr_retired", 32'(retired), 32'(m_ret));
      check("wr_flag_z", 32'(flag_z), 32'(m_z));
      check("wr_flag_c", 32'(flag_c), 32'(m_c));
      check("wr_no_we_after", 32'(rf_we), 32'd0);
      check("wr_in_ready", 32'(in_ready), 32'd1);
      tick;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_flag_z"}, 32'(flag_z), 32'd0);
    check({tag, "_flag_c"}, 32'(flag_c), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_retired"}, 32'(retired), 32'd0);
    m_z = 1'b0; m_c = 1'b0; m_err = 1'b0; m_ret = 8'd0;
    tick;
  endtask

  initial begin
    logic [7:0] b0, b1;
    logic [3:0] op;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    m_writes = 0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 8'($urandom);
      m_rf[i]   = rf_mem[i];
    end
    tick; tick;
    rst = 1'b0;
    check_reset_outputs("reset");

    do_instr(8'h31, 8'hA5, 0, 0);
    do_instr(8'h11, 8'hF0, 0, 0);
    do_instr(8'h21, 8'h20, 1, 0);
    do_instr(8'h43, 8'h21, 0, 0);
    do_instr(8'h54, 8'h11, 0, 0);
    do_instr(8'h73, 8'h00, 0, 5);
    do_instr(8'h09, 8'h00, 0, 0);
    do_instr(8'h00, 8'h00, 0, 0);
    do_instr(8'h66, 8'h43, 0, 0);

    // Reset while waiting for the operand of MOVI r3.
    send(8'h31, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_reset_outputs("midreset");
    check("midreset_writes", 32'(wr_count), 32'(m_writes));
    do_instr(8'h12, 8'h5A, 0, 0);

    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(0, 8));
      if (op == 4'h8) op = 4'($urandom_range(8, 15));
      b0 = {4'($urandom), op};
      b1 = 8'($urandom);
      do_instr(b0, b1, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    for (int k = 0; k < 256; k++) do_instr(8'h00, 8'h00, $urandom_range(0, 2), 0);
    check("nop_run_writes", 32'(wr_count), 32'(m_writes));

    for (int i = 0; i < 16; i++) check("final_rf", {24'(i), rf_mem[i]}, {24'(i), m_rf[i]});
    check("final_err", 32'(err), 32'(m_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Byte-stream instruction sequencer that drives the 16x8 general register file.
- Accepts opcode and operand bytes over a valid/ready input, decodes one- and two-byte instructions, and issues read and write strobes to an external register file (two async read ports, one sync write port).
- Executes simple ALU operations, maintains Z/C flags, and streams register values out through a valid/ready output.
- Sits between the chip pin interface and the register file.

Parameters:
- NREGS, 16, number of registers; register address width is clog2(NREGS)=4.
- DW, 8, register and data width.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  8  instruction or operand byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  sequencer accepts in_data this cycle.
- rf_raddr_a  output  4  register file read address A.
- rf_raddr_b  output  4  register file read address B.
- rf_rdata_a  input  8  combinational read data A.
- rf_rdata_b  input  8  combinational read data B.
- rf_we  output  1  write strobe; the write lands at the next posedge.
- rf_waddr  output  4  write address.
- rf_wdata  output  8  write data.
- out_data  output  8  register value emitted by OUT.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- flag_z  output  1  last ALU result was zero.
- flag_c  output  1  ADD carry-out / SUB borrow.
- err  output  1  sticky illegal-opcode flag.
- retired  output  8  retired instruction count; wraps at 255 -> 0.

Behaviour:
- Reset (rst=1 at posedge): state=FETCH. Reset values: in_ready=1, rf_we=0, out_valid=0, out_data=0, flag_z=0, flag_c=0, err=0, retired=0. Register file contents are untouched.
- Reset mid-instruction abandons the instruction: no write, no out beat, no retire.
- Byte0 format: [3:0]=opcode, [7:4]=rd. Byte1 (operand) meaning depends on the opcode.
- Opcodes:
  - 0x0 NOP: one byte; retires immediately.
  - 0x1 MOVI: byte1=imm; rf[rd]=imm.
  - 0x2 MOV: byte1[3:0]=rs; rf[rd]=rf[rs].
  - 0x3 ADD: byte1={rt,rs}; rf[rd]=(rf[rs]+rf[rt]) mod 256; C=carry-out.
  - 0x4 SUB: byte1={rt,rs}; rf[rd]=rf[rs]-rf[rt] mod 256; C=1 iff rf[rs]<rf[rt].
  - 0x5 AND and 0x6 XOR: byte1={rt,rs}; C cleared.
  - 0x7 OUT: one byte; emits rf[rd].
  - 0x8-0xF: illegal.
- Flags: Z and C update only on ADD/SUB/AND/XOR, in the EXEC cycle. Z=(result==0).
- FSM states: FETCH, OPND, EXEC, OUTW.
- FETCH: in_ready=1. On a handshake (in_valid&in_ready), latch opcode and rd, then:
  - NOP: retired++, stay in FETCH.
  - Illegal: err<=1, byte discarded, stay in FETCH, no retire.
  - OUT: go to EXEC.
  - Otherwise: go to OPND.
- OPND: in_ready=1. On a handshake, latch byte1 and go to EXEC.
- EXEC: in_ready=0, exactly one cycle.
  - Drive rf_raddr_a=rs and rf_raddr_b=rt (for OUT, rf_raddr_a=rd).
  - Write instructions: compute the result combinationally, rf_we=1, rf_waddr=rd, rf_wdata=result; retired++; go to FETCH.
  - OUT: latch out_data<=rf_rdata_a, set out_valid<=1, go to OUTW.
- OUTW: in_ready=0, out_valid=1, out_data held stable. On out_ready: out_valid<=0, retired++, go to FETCH.
- rf_we is high only in EXEC. rf_raddr_* are don't-care outside EXEC, but must be deterministic (drive the latched fields).
- Latency: a two-byte instruction whose bytes arrive back to back writes at the posedge ending the cycle after byte1. Throughput is 3 cycles per two-byte instruction, 1 per NOP.
- Read-after-write: the write commits at the EXEC posedge. A following instruction's EXEC is at least 2 cycles later, so it reads the new value with no forwarding.
- Equal addresses: rd==rs==rt is legal; reads use pre-write values.
- in_valid low in FETCH/OPND: hold state, no side effects.
- err clears only on rst.

Test Plan:
- Reset, then MOVI r3,0xA5 (bytes 0x31,0xA5) -> rf_we=1, waddr=3, wdata=0xA5 exactly 1 cycle after byte1 accepted; retired=1; in_ready=0 only during EXEC.
- MOVI r1,0xF0; MOVI r2,0x20; ADD r4,r1,r2 (0x43,0x21) -> wdata=0x10, C=1, Z=0. Then SUB r5,r1,r1 (0x54,0x11) -> wdata=0x00, Z=1, C=0.
- OUT r3 (0x73) with out_ready held low 5 cycles -> out_valid=1 and out_data=0xA5 stable throughout, in_ready=0. Raise out_ready -> one beat, then FETCH; retired increments once.
- Illegal byte 0x09, then NOP 0x00 -> err=1 sticky, no rf_we, retired +1 for the NOP only. Further legal instructions still execute.
- Assert rst during OPND after byte 0x31 -> no write; state=FETCH; all outputs at reset values the next cycle; the next 0x12 is decoded as a new opcode.
- Issue 256 NOPs with in_valid gaps inserted randomly -> retired wraps 255 -> 0; no writes occur.
